// File: rtl/cart_sched_pkg.sv
// ---------------------------------------------------------------------------
// cart_sched_pkg : shared types and constants for the cartridge bus scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TURN   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic OWN_EMU = 1'b0;
  localparam logic OWN_SYS = 1'b1;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cart_sched_timer.sv
// ---------------------------------------------------------------------------
// cart_sched_timer : loadable down-counter, stops at zero, reused per phase
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cart_sched_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o,
  output logic             done_next_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // done_next_o lets the owner register outputs that depend on the next cycle
  assign done_o      = (cnt_q == '0);
  assign done_next_o = (cnt_d == '0);

endmodule

`default_nettype wire

// File: rtl/cart_bus_sched.sv
// ---------------------------------------------------------------------------
// cart_bus_sched : arbitrates EMU/SYS onto the shared 8-bit cartridge bus and
// runs each grant as a timed SETUP/STROBE/HOLD transaction.
// Optional macro CART_SCHED_FAIR_EN : force a SYS grant after FAIR_LIMIT EMU grants.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cart_bus_sched
  import cart_sched_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned TURN_CYC   = 1,
  parameter int unsigned FAIR_LIMIT = 8
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        emu_req,
  input  logic        emu_we,
  input  logic        emu_cs,
  input  logic [15:0] emu_addr,
  input  logic [7:0]  emu_wdata,
  output logic        emu_ack,
  output logic [7:0]  emu_rdata,
  input  logic        sys_req,
  input  logic        sys_we,
  input  logic        sys_cs,
  input  logic [15:0] sys_addr,
  input  logic [7:0]  sys_wdata,
  output logic        sys_ack,
  output logic [7:0]  sys_rdata,
  input  logic        sys_allow,
  output logic [15:0] cart_a,
  output logic        cart_cs,
  output logic        cart_rd,
  output logic        cart_wr,
  output logic [7:0]  cart_dout,
  output logic        cart_oe,
  input  logic [7:0]  cart_din,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned CNT_W = $clog2(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC) + 1);
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TURN   = CNT_W'(TURN_CYC - 1);

  state_t state_q, state_d;
  logic              owner_q, owner_d;
  logic              lat_we_q, lat_we_d;
  logic              lat_cs_q, lat_cs_d;
  logic [15:0]       lat_addr_q, lat_addr_d;
  logic [7:0]        lat_wdata_q, lat_wdata_d;
  logic [7:0]        emu_rdata_q, emu_rdata_d;
  logic [7:0]        sys_rdata_q, sys_rdata_d;
  logic [15:0]       cart_a_q, cart_a_d;
  logic [7:0]        cart_dout_q, cart_dout_d;
  logic              cart_cs_q, cart_cs_d;
  logic              cart_rd_q, cart_rd_d;
  logic              cart_wr_q, cart_wr_d;
  logic              cart_oe_q, cart_oe_d;
  logic              emu_ack_q, emu_ack_d;
  logic              sys_ack_q, sys_ack_d;
  logic              busy_q, busy_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              tmr_done_next;

  logic              sys_ok;
  logic              force_sys;
  logic              grant_emu;
  logic              grant_sys;
  logic              drive;
  logic              ack_now;

  cart_sched_timer #(.WIDTH(CNT_W)) u_timer (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .done_o      (tmr_done),
    .done_next_o (tmr_done_next)
  );

  assign sys_ok    = sys_req & sys_allow;
  assign grant_emu = emu_req & ~force_sys;
  assign grant_sys = sys_ok & (~emu_req | force_sys);

`ifdef CART_SCHED_FAIR_EN
  localparam int unsigned FAIR_W = $clog2(FAIR_LIMIT + 1);
  logic [FAIR_W-1:0] fair_q, fair_d;

  assign force_sys = sys_ok & (fair_q >= FAIR_W'(FAIR_LIMIT));

  // Counts EMU grants that overtook a pending, allowed SYS request.
  always_comb begin
    fair_d = fair_q;
    if (!sys_ok) begin
      fair_d = '0;
    end else if (state_q == IDLE) begin
      if (grant_sys) begin
        fair_d = '0;
      end else if (grant_emu && (fair_q < FAIR_W'(FAIR_LIMIT))) begin
        fair_d = fair_q + FAIR_W'(1);
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      fair_q <= '0;
    end else begin
      fair_q <= fair_d;
    end
  end
`else
  assign force_sys = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_we_d    = lat_we_q;
    lat_cs_d    = lat_cs_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    emu_rdata_d = emu_rdata_q;
    sys_rdata_d = sys_rdata_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      IDLE: begin
        if (grant_emu || grant_sys) begin
          owner_d     = grant_emu ? OWN_EMU   : OWN_SYS;
          lat_we_d    = grant_emu ? emu_we    : sys_we;
          lat_cs_d    = grant_emu ? emu_cs    : sys_cs;
          lat_addr_d  = grant_emu ? emu_addr  : sys_addr;
          lat_wdata_d = grant_emu ? emu_wdata : sys_wdata;
          tmr_load    = 1'b1;
          // lat_we_q still holds the previous transaction's direction here
          if (lat_we_d != lat_we_q) begin
            state_d = TURN;
            tmr_val = LD_TURN;
          end else begin
            state_d = SETUP;
            tmr_val = LD_SETUP;
          end
        end
      end
      TURN: begin
        if (tmr_done) begin
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_d  = STROBE;
          tmr_load = 1'b1;
          tmr_val  = LD_STROBE;
        end
      end
      STROBE: begin
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
          if (!lat_we_q) begin
            if (owner_q == OWN_SYS) sys_rdata_d = cart_din;
            else                    emu_rdata_d = cart_din;
          end
        end
      end
      HOLD: begin
        if (tmr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad-side values are decoded from the next state so every output is a flop.
  always_comb begin
    drive       = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cart_cs_d   = drive & lat_cs_d;
    cart_oe_d   = drive & lat_we_d;
    cart_rd_d   = (state_d == STROBE) & ~lat_we_d;
    cart_wr_d   = (state_d == STROBE) & lat_we_d;
    cart_a_d    = drive ? lat_addr_d : cart_a_q;
    cart_dout_d = (drive && lat_we_d) ? lat_wdata_d : cart_dout_q;
    ack_now     = (state_d == HOLD) && tmr_done_next;
    emu_ack_d   = ack_now && (owner_d == OWN_EMU);
    sys_ack_d   = ack_now && (owner_d == OWN_SYS);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_EMU;
      lat_we_q    <= 1'b0;
      lat_cs_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      emu_rdata_q <= '0;
      sys_rdata_q <= '0;
      cart_a_q    <= '0;
      cart_dout_q <= '0;
      cart_cs_q   <= 1'b0;
      cart_rd_q   <= 1'b0;
      cart_wr_q   <= 1'b0;
      cart_oe_q   <= 1'b0;
      emu_ack_q   <= 1'b0;
      sys_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_we_q    <= lat_we_d;
      lat_cs_q    <= lat_cs_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      emu_rdata_q <= emu_rdata_d;
      sys_rdata_q <= sys_rdata_d;
      cart_a_q    <= cart_a_d;
      cart_dout_q <= cart_dout_d;
      cart_cs_q   <= cart_cs_d;
      cart_rd_q   <= cart_rd_d;
      cart_wr_q   <= cart_wr_d;
      cart_oe_q   <= cart_oe_d;
      emu_ack_q   <= emu_ack_d;
      sys_ack_q   <= sys_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign cart_a    = cart_a_q;
  assign cart_dout = cart_dout_q;
  assign cart_cs   = cart_cs_q;
  assign cart_rd   = cart_rd_q;
  assign cart_wr   = cart_wr_q;
  assign cart_oe   = cart_oe_q;
  assign emu_ack   = emu_ack_q;
  assign sys_ack   = sys_ack_q;
  assign emu_rdata = emu_rdata_q;
  assign sys_rdata = sys_rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_cart_bus_sched.sv
// ---------------------------------------------------------------------------
// tb_cart_bus_sched : directed vector table plus hand-written corner sequences
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cart_bus_sched;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        emu_req = 1'b0, emu_we = 1'b0, emu_cs = 1'b1;
  logic [15:0] emu_addr = '0;
  logic [7:0]  emu_wdata = '0;
  logic        sys_req = 1'b0, sys_we = 1'b0, sys_cs = 1'b1;
  logic [15:0] sys_addr = '0;
  logic [7:0]  sys_wdata = '0;
  logic        sys_allow = 1'b1;
  logic [7:0]  cart_din = '0;
  logic        emu_ack, sys_ack;
  logic [7:0]  emu_rdata, sys_rdata;
  logic [15:0] cart_a;
  logic        cart_cs, cart_rd, cart_wr, cart_oe;
  logic [7:0]  cart_dout;
  logic        busy, owner;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  cart_bus_sched dut (
    .pclk(pclk), .reset_n(reset_n),
    .emu_req(emu_req), .emu_we(emu_we), .emu_cs(emu_cs), .emu_addr(emu_addr),
    .emu_wdata(emu_wdata), .emu_ack(emu_ack), .emu_rdata(emu_rdata),
    .sys_req(sys_req), .sys_we(sys_we), .sys_cs(sys_cs), .sys_addr(sys_addr),
    .sys_wdata(sys_wdata), .sys_ack(sys_ack), .sys_rdata(sys_rdata),
    .sys_allow(sys_allow),
    .cart_a(cart_a), .cart_cs(cart_cs), .cart_rd(cart_rd), .cart_wr(cart_wr),
    .cart_dout(cart_dout), .cart_oe(cart_oe), .cart_din(cart_din),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic        is_sys;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          exp_lat;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  // Returns the number of posedges until the selected ack is seen, -1 on timeout.
  task automatic wait_ack(input bit is_sys, input int maxc, output int cyc);
    cyc = -1;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if ((is_sys ? sys_ack : emu_ack) === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cyc2, cnt, eacks;

    vecs[0] = '{1'b0, 1'b0, 16'h0147, 8'h00, 8'h1B, 7, 8'h1B};
    vecs[1] = '{1'b0, 1'b1, 16'h2000, 8'h5A, 8'h00, 8, 8'h1B};
    vecs[2] = '{1'b0, 1'b1, 16'hA000, 8'hC3, 8'h00, 7, 8'h1B};
    vecs[3] = '{1'b1, 1'b0, 16'h0134, 8'h00, 8'h4E, 8, 8'h4E};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 8'hFF, 8'h00, 8, 8'h4E};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 16'h7FFF, 8'h00, 8'hA5, 7, 8'hA5};

    // reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_strobes", {28'd0, cart_cs, cart_rd, cart_wr, cart_oe}, 0);
    chk("rst_acks", {30'd0, emu_ack, sys_ack}, 0);
    chk("rst_owner", {31'd0, owner}, 0);
    chk("rst_a_dout", {8'd0, cart_a, cart_dout}, 0);
    chk("rst_rdata", {16'd0, emu_rdata, sys_rdata}, 0);
    repeat (2) @(negedge pclk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      vec_t v;
      int ack_cyc, other, smask, bad;
      v = vecs[i];
      ack_cyc = -1; other = 0; smask = 0; bad = 0;
      emu_we = v.we; emu_addr = v.addr; emu_wdata = v.wdata;
      sys_we = v.we; sys_addr = v.addr; sys_wdata = v.wdata;
      cart_din = v.din; sys_allow = 1'b1;
      emu_req = ~v.is_sys; sys_req = v.is_sys;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (cart_rd || cart_wr) begin
          smask = smask | (1 << c);
          if (cart_rd !== ~v.we || cart_wr !== v.we || cart_a !== v.addr ||
              cart_oe !== v.we || cart_cs !== 1'b1 || (v.we && cart_dout !== v.wdata))
            bad++;
        end
        if ((v.is_sys ? emu_ack : sys_ack) === 1'b1) other++;
        if ((v.is_sys ? sys_ack : emu_ack) === 1'b1) begin
          ack_cyc = c;
          emu_req = 1'b0; sys_req = 1'b0;
          break;
        end
      end
      emu_req = 1'b0; sys_req = 1'b0;
      chk($sformatf("v%0d_ack_cycle", i), ack_cyc, v.exp_lat);
      chk($sformatf("v%0d_rdata", i), v.is_sys ? sys_rdata : emu_rdata, v.exp_rdata);
      chk($sformatf("v%0d_owner", i), {31'd0, owner}, {31'd0, v.is_sys});
      chk($sformatf("v%0d_strobe_window", i), smask, 32'hF << (v.exp_lat - 4));
      chk($sformatf("v%0d_strobe_values", i), bad, 0);
      chk($sformatf("v%0d_other_ack", i), other, 0);
      tick();
      chk($sformatf("v%0d_idle_after", i), {29'd0, busy, cart_cs, cart_oe}, 0);
    end

    // write then read back-to-back: turnaround before the read
    emu_we = 1'b1; emu_addr = 16'h1234; emu_wdata = 8'h99; emu_req = 1'b1;
    wait_ack(1'b0, 20, cyc);
    chk("wr_rd_write_ack", cyc, 8);
    emu_we = 1'b0; emu_addr = 16'h5678; cart_din = 8'h77;
    tick();
    chk("wr_rd_idle_gap", {31'd0, busy}, 0);
    tick();
    chk("wr_rd_turn", {28'd0, busy, cart_oe, cart_cs, cart_rd}, 32'h8);
    wait_ack(1'b0, 20, cyc);
    emu_req = 1'b0;
    chk("wr_rd_read_ack", (cyc < 0) ? -1 : cyc + 1, 8);
    chk("wr_rd_rdata", emu_rdata, 8'h77);

    // SYS blocked while sys_allow is low
    sys_we = 1'b0; sys_addr = 16'h0100; cart_din = 8'h21;
    sys_allow = 1'b0; sys_req = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy || sys_ack) cnt++;
    end
    chk("allow_low_no_grant", cnt, 0);
    sys_allow = 1'b1;
    wait_ack(1'b1, 20, cyc);
    sys_req = 1'b0;
    chk("allow_rise_ack", cyc, 7);
    chk("allow_rise_rdata", sys_rdata, 8'h21);
    tick();

    // simultaneous requests: EMU first, SYS next
    emu_we = 1'b0; emu_addr = 16'h0200; sys_we = 1'b0; sys_addr = 16'h0300;
    cart_din = 8'h3C; emu_req = 1'b1; sys_req = 1'b1;
    cyc = -1; cyc2 = -1;
    for (int c = 1; c <= 40 && cyc2 < 0; c++) begin
      tick();
      if (emu_ack) begin cyc = c; emu_req = 1'b0; end
      if (sys_ack) begin cyc2 = c; sys_req = 1'b0; end
    end
    emu_req = 1'b0; sys_req = 1'b0;
    chk("simul_emu_ack", cyc, 7);
    chk("simul_sys_ack", cyc2, 15);
    chk("simul_rdata", {16'd0, emu_rdata, sys_rdata}, 32'h3C3C);
    chk("simul_owner", {31'd0, owner}, 1);
    tick();

    // asynchronous reset during STROBE
    emu_we = 1'b0; emu_addr = 16'h0400; cart_din = 8'h55; emu_req = 1'b1;
    repeat (4) tick();
    chk("rst_mid_strobe_active", {31'd0, cart_rd}, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_drop", {27'd0, cart_rd, cart_wr, cart_cs, busy, emu_ack}, 0);
    chk("rst_mid_rdata", emu_rdata, 0);
    emu_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (emu_ack || busy) cnt++;
    end
    chk("rst_mid_no_ack", cnt, 0);
    reset_n = 1'b1;
    tick();
    emu_addr = 16'h0401; cart_din = 8'h66; emu_req = 1'b1;
    wait_ack(1'b0, 20, cyc);
    emu_req = 1'b0;
    chk("after_rst_ack", cyc, 7);
    chk("after_rst_rdata", emu_rdata, 8'h66);
    tick();

`ifdef CART_SCHED_FAIR_EN
    // EMU hammering while SYS waits: SYS forced in after FAIR_LIMIT EMU grants
    emu_we = 1'b0; sys_we = 1'b0; sys_allow = 1'b1;
    emu_req = 1'b1; sys_req = 1'b1;
    eacks = 0; cyc = -1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (emu_ack) eacks++;
      if (sys_ack) begin cyc = c; break; end
    end
    emu_req = 1'b0; sys_req = 1'b0;
    chk("fair_sys_served", (cyc > 0) ? 1 : 0, 1);
    chk("fair_emu_acks_before_sys", eacks, 8);
    tick();
`else
    eacks = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
